// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: drives one row low at a time, debounces whole scan
// frames and reports key press/release events through a one-entry valid/ready register.
module keypad_scan_debounce #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DEBOUNCE       = 3,
  parameter int CODE_W         = 4,
  parameter int REPORT_RELEASE = 0
) (
  input  logic                 clk_5000hz,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      col,
  output logic [ROWS-1:0]      row,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [CODE_W-1:0]    key_code,
  output logic                 key_release,
  output logic                 key_multi,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  // state     | meaning
  // PH_SETTLE | drive row[row_idx] low, give the columns a cycle to settle
  // PH_SAMPLE | capture col into raw, advance row_idx; last row closes the frame
  typedef enum logic {PH_SETTLE = 1'b0, PH_SAMPLE = 1'b1} phase_t;

  localparam int              N        = ROWS * COLS;
  localparam int              RW       = $clog2(ROWS);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
  localparam logic [3:0]      DEB      = 4'(DEBOUNCE);

  phase_t              phase;
  logic [RW-1:0]       row_idx;
  logic [N-1:0]        raw;
  logic [N-1:0]        prev_frame;
  logic [N-1:0]        frame;
  logic [N-1:0]        ks_old;
  logic [3:0]          stable_cnt;
  logic [3:0]          cnt_next;
  logic                evt_pend;

  logic [N-1:0]        press_set;
  logic [N-1:0]        rel_set;
  logic [N-1:0]        cand_set;
  logic                cand_any;
  logic                cand_rel;
  logic                cand_multi;
  logic [CODE_W-1:0]   cand_code;
  logic                accept;

  // The frame includes the columns being captured on the closing edge.
  always_comb begin
    frame = raw;
    frame[(ROWS-1)*COLS +: COLS] = col;
  end

  always_comb begin
    cnt_next = stable_cnt;
    if (frame != prev_frame)
      cnt_next = 4'd1;
    else if (stable_cnt != DEB)
      cnt_next = stable_cnt + 4'd1;
  end

  always_ff @(posedge clk_5000hz or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= PH_SETTLE;
      row        <= '1;
      row_idx    <= '0;
      raw        <= '1;
      prev_frame <= '1;
      stable_cnt <= '0;
      key_state  <= '1;
      ks_old     <= '1;
      evt_pend   <= 1'b0;
    end else begin
      evt_pend <= 1'b0;
      case (phase)
        PH_SETTLE: begin
          row   <= ~(ROWS'(1) << row_idx);
          phase <= PH_SAMPLE;
        end
        PH_SAMPLE: begin
          raw[row_idx*COLS +: COLS] <= col;
          phase <= PH_SETTLE;
          if (row_idx == LAST_ROW) begin
            row_idx    <= '0;
            stable_cnt <= cnt_next;
            prev_frame <= frame;
            if (cnt_next == DEB) begin
              key_state <= frame;
              ks_old    <= key_state;
              evt_pend  <= 1'b1;
            end
          end else begin
            row_idx <= row_idx + RW'(1);
          end
        end
        default: phase <= PH_SETTLE;
      endcase
    end
  end

  // Presses take priority; releases only count when they are reported at all.
  always_comb begin
    press_set = ks_old & ~key_state;
    rel_set   = '0;
    if (REPORT_RELEASE != 0)
      rel_set = ~ks_old & key_state;
    cand_set   = (press_set != '0) ? press_set : rel_set;
    cand_rel   = (press_set == '0);
    cand_any   = evt_pend && (cand_set != '0);
    cand_multi = (cand_set & (cand_set - N'(1))) != '0;
    cand_code  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (cand_set[i]) cand_code = CODE_W'(i);
  end

  assign accept = key_valid & key_ready;

  always_ff @(posedge clk_5000hz or negedge rst_n) begin
    if (!rst_n) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_release <= 1'b0;
      key_multi   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (cand_any) begin
        if (!key_valid || accept) begin
          key_valid   <= 1'b1;
          key_code    <= cand_code;
          key_release <= cand_rel;
          key_multi   <= cand_multi;
        end
      end else if (accept) begin
        key_valid <= 1'b0;
      end
      if (ovf_clr)
        overflow <= 1'b0;
      if (cand_any && key_valid && !key_ready)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: two instances (release reporting off/on) fed by a
// keypad model, compared every cycle with a frame-level reference model.
module tb_keypad_scan_debounce;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;
  localparam int DEB  = 3;
  localparam int CW   = 4;

  logic clk_5000hz = 1'b0;
  logic rst_n      = 1'b0;
  logic key_ready  = 1'b1;
  logic ovf_clr    = 1'b0;
  logic [N-1:0] pressed = '0;

  logic [COLS-1:0] d_col   [2];
  logic [ROWS-1:0] d_row   [2];
  logic [N-1:0]    d_ks    [2];
  logic            d_valid [2];
  logic [CW-1:0]   d_code  [2];
  logic            d_rel   [2];
  logic            d_multi [2];
  logic            d_ovf   [2];

  int checks = 0;
  int errors = 0;

  always #100 clk_5000hz = ~clk_5000hz;

  function automatic logic [COLS-1:0] keypad_col(input logic [ROWS-1:0] r, input logic [N-1:0] p);
    logic [COLS-1:0] c;
    c = '1;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (!r[rr] && p[rr*COLS+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign d_col[0] = keypad_col(d_row[0], pressed);
  assign d_col[1] = keypad_col(d_row[1], pressed);

  keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB), .CODE_W(CW), .REPORT_RELEASE(0)) u_dut0 (
    .clk_5000hz(clk_5000hz), .rst_n(rst_n), .col(d_col[0]), .row(d_row[0]),
    .key_state(d_ks[0]), .key_valid(d_valid[0]), .key_ready(key_ready),
    .key_code(d_code[0]), .key_release(d_rel[0]), .key_multi(d_multi[0]),
    .overflow(d_ovf[0]), .ovf_clr(ovf_clr));

  keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEB), .CODE_W(CW), .REPORT_RELEASE(1)) u_dut1 (
    .clk_5000hz(clk_5000hz), .rst_n(rst_n), .col(d_col[1]), .row(d_row[1]),
    .key_state(d_ks[1]), .key_valid(d_valid[1]), .key_ready(key_ready),
    .key_code(d_code[1]), .key_release(d_rel[1]), .key_multi(d_multi[1]),
    .overflow(d_ovf[1]), .ovf_clr(ovf_clr));

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // Reference model: edge count since reset decides which row is driven/sampled.
  int           m_e;
  int           m_cnt;
  logic [N-1:0] m_raw, m_P, m_ks, m_ksold;
  bit           m_pend;
  bit           mv [2];
  int           mcode [2];
  bit           mrel [2];
  bit           mmul [2];
  bit           movf [2];

  task automatic model_reset();
    m_e = 0; m_cnt = 0; m_raw = '1; m_P = '1; m_ks = '1; m_ksold = '1; m_pend = 0;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mcode[i] = 0; mrel[i] = 0; mmul[i] = 0; movf[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] pr, rl, set;
    int idx, r;
    bit acc, ovf_set;
    pr = m_ksold & ~m_ks;
    rl = ~m_ksold & m_ks;
    for (int i = 0; i < 2; i++) begin
      acc = mv[i] && key_ready;
      set = '0;
      if (m_pend) set = (pr != '0) ? pr : ((i == 1) ? rl : '0);
      ovf_set = 0;
      if (set != '0) begin
        idx = 0;
        for (int b = N - 1; b >= 0; b--) if (set[b]) idx = b;
        if (!mv[i] || acc) begin
          mv[i] = 1; mcode[i] = idx; mrel[i] = (pr == '0); mmul[i] = ($countones(set) > 1);
        end else ovf_set = 1;
      end else if (acc) mv[i] = 0;
      if (ovf_clr) movf[i] = 0;
      if (ovf_set) movf[i] = 1;
    end
    m_pend = 0;
    m_e++;
    if (m_e % 2 == 0) begin
      r = (m_e / 2 - 1) % ROWS;
      for (int c = 0; c < COLS; c++) m_raw[r*COLS+c] = !pressed[r*COLS+c];
      if (r == ROWS - 1) begin
        if (m_raw != m_P) m_cnt = 1;
        else if (m_cnt < DEB) m_cnt++;
        m_P = m_raw;
        if (m_cnt == DEB) begin m_ksold = m_ks; m_ks = m_raw; m_pend = 1; end
      end
    end
  endtask

  always @(posedge clk_5000hz) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge rst_n) model_reset();

  function automatic logic [ROWS-1:0] m_row();
    logic [ROWS-1:0] one;
    one = 1;
    if (m_e == 0) return '1;
    return ~(one << (((m_e - 1) / 2) % ROWS));
  endfunction

  // Event log: outputs snapshotted at negedge, accepted at the following posedge.
  logic [5:0] lg0[$];
  logic [5:0] lg1[$];
  logic [5:0] snap [2];
  bit         snap_v [2];

  always @(negedge clk_5000hz) begin
    for (int i = 0; i < 2; i++) begin
      chk("row", i, d_row[i], m_row());
      chk("key_state", i, d_ks[i], m_ks);
      chk("key_valid", i, d_valid[i], mv[i]);
      chk("key_code", i, d_code[i], mcode[i]);
      chk("key_release", i, d_rel[i], mrel[i]);
      chk("key_multi", i, d_multi[i], mmul[i]);
      chk("overflow", i, d_ovf[i], movf[i]);
      snap_v[i] = d_valid[i];
      snap[i]   = {d_multi[i], d_rel[i], d_code[i]};
    end
  end

  always @(posedge clk_5000hz) begin
    if (rst_n && key_ready) begin
      if (snap_v[0]) lg0.push_back(snap[0]);
      if (snap_v[1]) lg1.push_back(snap[1]);
    end
  end

  task automatic run_to(input int n);
    while (m_e < n) @(negedge clk_5000hz);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_5000hz);
    rst_n = 1'b1;
    lg0.delete();
    lg1.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_5000hz);

    // Hold key 6 from frame 1: state at edge 24, event at edge 25.
    pressed = N'(1) << 6;
    do_reset();
    run_to(23);
    chk("t1_ks_before", 0, d_ks[0], 16'hFFFF);
    run_to(24);
    chk("t1_ks_load", 0, d_ks[0], 16'hFFBF);
    chk("t1_valid_early", 0, d_valid[0], 0);
    run_to(25);
    chk("t1_valid", 0, d_valid[0], 1);
    chk("t1_code", 0, d_code[0], 6);
    chk("t1_rel", 0, d_rel[0], 0);
    chk("t1_multi", 0, d_multi[0], 0);
    run_to(40);
    chk("t1_events", 0, lg0.size(), 1);
    chk("t1_events", 1, lg1.size(), 1);

    // Bounce: closed, open, then closed -> load at end of frame 5.
    pressed = N'(1) << 6;
    do_reset();
    run_to(8);  pressed = '0;
    run_to(16); pressed = N'(1) << 6;
    run_to(32);
    chk("t2_ks_frame4", 0, d_ks[0], 16'hFFFF);
    run_to(40);
    chk("t2_ks_frame5", 0, d_ks[0], 16'hFFBF);
    chk("t2_no_event", 0, lg0.size(), 0);
    run_to(60);
    chk("t2_events", 0, lg0.size(), 1);
    chk("t2_code", 0, (lg0.size() > 0) ? lg0[0] : 6'h3F, 6'h06);

    // Keys 5 and 10 together.
    pressed = (N'(1) << 5) | (N'(1) << 10);
    do_reset();
    run_to(25);
    chk("t3_ks", 0, d_ks[0], 16'hFBDF);
    chk("t3_code", 0, d_code[0], 5);
    chk("t3_multi", 0, d_multi[0], 1);
    chk("t3_multi", 1, d_multi[1], 1);
    run_to(40);
    chk("t3_events", 0, lg0.size(), 1);

    // Consumer stalled: second event is dropped and flagged.
    pressed = N'(1) << 3;
    key_ready = 1'b0;
    do_reset();
    run_to(25);
    chk("t4_valid", 0, d_valid[0], 1);
    chk("t4_code", 0, d_code[0], 3);
    run_to(32); pressed = N'(1) << 9;
    run_to(56);
    chk("t4_ovf_before", 0, d_ovf[0], 0);
    run_to(58);
    chk("t4_ovf", 0, d_ovf[0], 1);
    chk("t4_ovf", 1, d_ovf[1], 1);
    chk("t4_code_held", 0, d_code[0], 3);
    chk("t4_code_held", 1, d_code[1], 3);
    key_ready = 1'b1;
    run_to(59);
    chk("t4_valid_drop", 0, d_valid[0], 0);
    chk("t4_ovf_sticky", 0, d_ovf[0], 1);
    ovf_clr = 1'b1;
    run_to(60);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 0, d_ovf[0], 0);
    chk("t4_events", 0, lg0.size(), 1);

    // Press and release key 15: only the release-reporting instance sees two events.
    pressed = N'(1) << 15;
    do_reset();
    run_to(32); pressed = '0;
    run_to(70);
    chk("t5_events", 0, lg0.size(), 1);
    chk("t5_events", 1, lg1.size(), 2);
    chk("t5_press", 1, (lg1.size() > 0) ? lg1[0] : 6'h3F, 6'h0F);
    chk("t5_release", 1, (lg1.size() > 1) ? lg1[1] : 6'h3F, 6'h1F);
    chk("t5_ks", 1, d_ks[1], 16'hFFFF);

    // Reset in frame 2 of a key-0 press, then a full debounce from scratch.
    pressed = N'(1) << 0;
    do_reset();
    run_to(12);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_row", 0, d_row[0], 4'hF);
    chk("t6_ks", 0, d_ks[0], 16'hFFFF);
    chk("t6_valid", 0, d_valid[0], 0);
    chk("t6_code", 0, d_code[0], 0);
    chk("t6_flags", 0, {d_rel[0], d_multi[0], d_ovf[0]}, 0);
    repeat (2) @(negedge clk_5000hz);
    rst_n = 1'b1;
    lg0.delete();
    run_to(1);
    chk("t6_row0", 0, d_row[0], 4'hE);
    run_to(23);
    chk("t6_ks_before", 0, d_ks[0], 16'hFFFF);
    run_to(24);
    chk("t6_ks_load", 0, d_ks[0], 16'hFFFE);
    run_to(25);
    chk("t6_valid", 0, d_valid[0], 1);
    chk("t6_code0", 0, d_code[0], 0);
    run_to(30);
    pressed = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner for ROWS x COLS keypads. It drives one row low at a time with a settle cycle before sampling, and debounces whole scan frames. It keeps a debounced key-state vector and emits encoded press (and optionally release) events over a single-entry valid/ready handshake. It sits between the keypad pins and the calculator input decoder.

## Interface
- ROWS, 4, number of row lines driven (2..8)
- COLS, 4, number of column lines sampled (2..8)
- DEBOUNCE, 3, consecutive identical frames required to accept a new raw state (1..15)
- CODE_W, 4, key code width; must satisfy 2**CODE_W >= ROWS*COLS
- REPORT_RELEASE, 0, 1 = also queue release events

- clk_5000hz  in  1  scan clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset
- col  in  COLS  column lines, active-low (0 = key in driven row closed)
- row  out  ROWS  row drive, exactly one bit 0 outside reset, others 1
- key_state  out  ROWS*COLS  debounced state, bit r*COLS+c, 1 = released, 0 = pressed
- key_valid  out  1  event holding register full
- key_ready  in  1  consumer accepts event on edge where key_valid & key_ready
- key_code  out  CODE_W  r*COLS+c of event key
- key_release  out  1  0 = press event, 1 = release event
- key_multi  out  1  other same-type transitions in the same update were dropped
- overflow  out  1  sticky: an event was lost because the register was full
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Scan: row_idx 0..ROWS-1, phase 0/1. Phase 0: row[row_idx] driven low (settle). Phase 1: col sampled into raw[row_idx*COLS +: COLS], then row_idx advances, wrapping ROWS-1 -> 0. Frame = 2*ROWS cycles.
- Frame end = phase-1 edge of row ROWS-1. The frame vector F (including the columns captured at that edge) is compared with the previous frame vector P.
  - F != P: stable_cnt <= 1. F == P: stable_cnt <= min(stable_cnt+1, DEBOUNCE).
  - If the new stable_cnt == DEBOUNCE: key_state <= F. A repeat load of an unchanged value is harmless.
  - P <= F.
- Event detect: one cycle after each key_state load, compare new key_state against its prior value.
  - Press set = bits 1->0. Release set = bits 0->1 (used only if REPORT_RELEASE=1).
  - Candidate: lowest-index press bit. If there is none, the lowest-index release bit.
  - key_multi = 1 if the chosen set has more than one bit.
- Holding register:
  - Empty, or accepted on this edge: load the candidate and set key_valid.
  - Full and not accepted: drop the candidate and set overflow. key_code, key_release and key_multi are unchanged.
  - Accept with no candidate: key_valid <= 0.
- overflow is cleared by ovf_clr. If a set and ovf_clr occur on the same edge, the set wins.

## Timing
- Reset (async, immediate):
  - row = all 1
  - key_state = all 1
  - raw and P = all 1
  - stable_cnt = 0, row_idx = 0, phase = 0
  - key_valid = 0, key_code = 0, key_release = 0, key_multi = 0, overflow = 0
- First edge after reset release: row[0] goes low.
- Press latency: the key must be stable from the start of frame k. key_state updates at the end of frame k+DEBOUNCE-1. key_valid rises one edge later.
- A bounce in any frame restarts the count. An event only fires after DEBOUNCE clean frames.
- key_valid, key_code, key_release and key_multi are held stable while key_valid=1 and key_ready=0.
- key_ready while key_valid=0 is ignored.
- Reset mid-frame aborts the scan and discards the pending event. The first frame after reset compares against all-1 P.

## Test plan
- Bench keypad model drives col from row and a pressed-key set. Parameters 4x4, DEBOUNCE=3, key_ready=1.
  - Hold key 6 (row1, col2) -> key_state[6]=0 at the end of the 3rd frame; one key_valid pulse with key_code=6, key_release=0, key_multi=0.
- Key 6 bounce: closed in frame 1, open in frame 2, closed from frame 3 on -> no event before the end of frame 5; exactly one event, code 6.
- Keys 5 and 10 closed in the same frame -> one event, key_code=5, key_multi=1; key_state[5]=0 and key_state[10]=0.
- key_ready=0: press 3 -> valid, code 3. Release 3, press 9 -> overflow=1, code stays 3. Assert key_ready -> valid drops. Pulse ovf_clr -> overflow=0.
- REPORT_RELEASE=1: press then release key 15 -> two events: code 15 with key_release=0, then code 15 with key_release=1.
- Assert rst_n=0 during frame 2 of a press on key 0 -> all outputs return to their reset values immediately. After release, a full DEBOUNCE frames are needed before code 0 appears.
